reg_bank_mp: RTL

REG_BANK_MP -- requirements
Module: reg_bank_mp

---
 rtl/reg_bank_mp_pkg.sv | 23 ++
 rtl/reg_bank_mp_if.sv | 21 ++
 rtl/reg_bank_mp_clr_seq.sv | 51 +++++
 rtl/reg_bank_mp.sv | 62 ++++++
 4 files changed

// File: rtl/reg_bank_mp_pkg.sv
// Shared types, default sizes and helpers for the reg_bank_mp register bank.
package reg_bank_mp_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NREAD_DEF = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Ceiling log2, minimum 1 so a two-entry bank still gets a one-bit index.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Write/read bus bundle of the reg_bank_mp register bank.
interface reg_bank_mp_if
  import reg_bank_mp_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NREAD = NREAD_DEF
);
  localparam int unsigned AW = clog2(NREGS);

  logic                  we;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wdata;
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic                  ready;

  modport master (output we, waddr, wdata, raddr, input rdata, ready);
  modport slave  (input we, waddr, wdata, raddr, output rdata, ready);

endinterface

// File: rtl/reg_bank_mp_clr_seq.sv
// Post-reset clear sequencer: walks every register index once, then signals ready.
module reg_bank_mp_clr_seq
  import reg_bank_mp_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;

  // One clear write per cycle; READY is left only through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign clr_we_o   = (state_q == CLEAR) && !reset;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank with hardwired-zero x0 and a post-reset clear.
// Define REG_BANK_MP_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_bank_mp
  import reg_bank_mp_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NREAD = NREAD_DEF,
  localparam int unsigned AW    = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic                  ready
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_en;

  reg_bank_mp_clr_seq #(
    .NREGS (NREGS)
  ) u_clr_seq (
    .clk        (clk),
    .reset      (reset),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Architectural writes only once the bank is cleared and the index is real.
  assign wr_en = we && ready && (waddr != '0) && (32'(waddr) < NREGS);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          byp;

    assign ra  = raddr[g*AW +: AW];
    assign hit = ready && !reset && (ra != '0) && (32'(ra) < NREGS);
`ifdef REG_BANK_MP_BYPASS_EN
    assign byp = wr_en && (ra == waddr);
`else
    assign byp = 1'b0;
`endif
    assign rdata[g*XLEN +: XLEN] = !hit ? '0 : (byp ? wdata : mem_q[ra]);
  end

endmodule
